// File: rtl/aes_block_loader.sv
// aes_block_loader: collects four stream words into one plaintext block.
// It latches the per-block key ROM address, then issues a one-cycle start
// to the AES top and waits for its done before taking the next block.
// It also keeps a wrapping count of completed blocks.
// Optional build macro AES_LOADER_TIMEOUT_EN adds a WAIT watchdog. When it
// expires without done, err pulses and the loader drops the request.
module aes_block_loader #(
  parameter int aes_len        = 128,
  parameter int word_width     = 32,
  parameter int addr_width     = 5,
  parameter int cnt_width      = 16,
  parameter int timeout_cycles = 1024
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [word_width-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [addr_width-1:0] key_sel,
  input  logic                  flush,
  output logic [aes_len-1:0]    plaintext,
  output logic [addr_width-1:0] key_addr,
  output logic                  start,
  input  logic                  done,
  output logic                  busy,
  output logic [cnt_width-1:0]  block_count,
  output logic                  err
);

  localparam int NUM_WORDS = 4;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2
  } state_e;

  state_e                state_q;
  logic [1:0]            word_cnt_q;
  logic [1:0]            word_cnt_d;
  logic [aes_len-1:0]    plaintext_q;
  logic [addr_width-1:0] key_addr_q;
  logic                  start_q;
  logic                  busy_q;
  logic                  s_ready_q;
  logic [cnt_width-1:0]  block_count_q;
  logic [cnt_width-1:0]  block_count_d;

  // s_ready_q is only high in COLLECT, so accept implies COLLECT.
  // A flush in the same cycle discards the word.
  logic                  xfer;
  logic                  accept;
  logic                  last_word;
  logic [NUM_WORDS-1:0]  lane_we;

  assign xfer          = s_valid && s_ready_q;
  assign accept        = xfer && !flush;
  assign last_word     = (word_cnt_q == 2'd3);
  assign word_cnt_d    = word_cnt_q + 2'd1;
  assign block_count_d = block_count_q + cnt_width'(1);

  // Lane gi holds word number (3 - gi), so the first word lands in the top lane.
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_lane_we
    assign lane_we[gi] = accept && (word_cnt_q == 2'(NUM_WORDS - 1 - gi));
  end

`ifdef AES_LOADER_TIMEOUT_EN
  localparam int WD_W = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(timeout_cycles - 1);

  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;
  logic            err_q;

  assign wd_d = wd_q + WD_W'(1);
  assign err  = err_q;
`else
  // Without the watchdog the timeout parameter has no consumer.
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(timeout_cycles);
  assign err        = 1'b0;
`endif

  // Plaintext lanes load only in COLLECT, so the block is frozen through ISSUE and WAIT.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      plaintext_q <= '0;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (lane_we[i]) begin
          plaintext_q[i*word_width +: word_width] <= s_data;
        end
      end
    end
  end

  // Control FSM: COLLECT -> ISSUE (start pulse) -> WAIT (until done) -> COLLECT.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_COLLECT;
      word_cnt_q    <= 2'd0;
      key_addr_q    <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      s_ready_q     <= 1'b1;
      block_count_q <= '0;
`ifdef AES_LOADER_TIMEOUT_EN
      wd_q          <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        ST_COLLECT: begin
          if (flush) begin
            word_cnt_q <= 2'd0;
          end else if (xfer) begin
            word_cnt_q <= word_cnt_d;
            if (word_cnt_q == 2'd0) begin
              key_addr_q <= key_sel;
            end
            if (last_word) begin
              state_q   <= ST_ISSUE;
              start_q   <= 1'b1;
              busy_q    <= 1'b1;
              s_ready_q <= 1'b0;
            end
          end
        end

        ST_ISSUE: begin
          state_q <= ST_WAIT;
`ifdef AES_LOADER_TIMEOUT_EN
          wd_q    <= '0;
`endif
        end

        ST_WAIT: begin
          if (done) begin
            block_count_q <= block_count_d;
            state_q       <= ST_COLLECT;
            busy_q        <= 1'b0;
            s_ready_q     <= 1'b1;
          end
`ifdef AES_LOADER_TIMEOUT_EN
          else if (wd_q == WD_LAST) begin
            err_q     <= 1'b1;
            state_q   <= ST_COLLECT;
            busy_q    <= 1'b0;
            s_ready_q <= 1'b1;
          end else begin
            wd_q <= wd_d;
          end
`endif
        end

        default: begin
          state_q    <= ST_COLLECT;
          word_cnt_q <= 2'd0;
          busy_q     <= 1'b0;
          s_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign plaintext   = plaintext_q;
  assign key_addr    = key_addr_q;
  assign start       = start_q;
  assign busy        = busy_q;
  assign block_count = block_count_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Testbench for aes_block_loader.
// Expected blocks are queued as they are driven and compared on each start pulse.
`timescale 1ns/1ps
module tb_aes_block_loader;

  localparam int AES_LEN = 128;
  localparam int WW      = 32;
  localparam int AW      = 5;
  localparam int CW      = 6;
  localparam int TO      = 16;

  logic           clk = 1'b0;
  logic           nrst;
  logic [WW-1:0]  s_data;
  logic           s_valid;
  logic           s_ready;
  logic [AW-1:0]  key_sel;
  logic           flush;
  logic [AES_LEN-1:0] plaintext;
  logic [AW-1:0]  key_addr;
  logic           start;
  logic           done;
  logic           done_man;
  logic           done_auto = 1'b0;
  logic           busy;
  logic [CW-1:0]  block_count;
  logic           err;

  int n_checks = 0;
  int n_fail   = 0;
  int start_count = 0;
  int exp_count = 0;

  bit resp_en    = 1'b0;
  int resp_delay = 0;

  logic [AES_LEN+AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  assign done = done_man | done_auto;

  aes_block_loader #(
    .aes_len(AES_LEN), .word_width(WW), .addr_width(AW),
    .cnt_width(CW), .timeout_cycles(TO)
  ) dut (
    .clk(clk), .nrst(nrst), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .key_sel(key_sel), .flush(flush),
    .plaintext(plaintext), .key_addr(key_addr), .start(start),
    .done(done), .busy(busy), .block_count(block_count), .err(err)
  );

  // Monitor: pops the scoreboard on each start, and optionally answers with done.
  bit prev_start = 1'b0;
  bit resp_pending = 1'b0;
  int resp_cnt = 0;
  always begin
    logic [AES_LEN+AW-1:0] item;
    @(posedge clk);
    #1;
    done_auto = 1'b0;
    if (resp_pending) begin
      if (resp_cnt == 0) begin
        done_auto = 1'b1;
        resp_pending = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
    if (start === 1'b1) begin
      start_count++;
      n_checks++;
      if (prev_start) begin
        n_fail++;
        $display("FAIL start_width: start high on consecutive cycles, required single-cycle pulse");
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: start with no expected block pending");
      end else begin
        item = exp_q.pop_front();
        if ({plaintext, key_addr} !== item) begin
          n_fail++;
          $display("FAIL sb_block: got pt=%h key=%0d, required pt=%h key=%0d",
                   plaintext, key_addr, item[AES_LEN+AW-1:AW], item[AW-1:0]);
        end else begin
          $display("block ok: pt=%h key=%0d", plaintext, key_addr);
        end
      end
      if (resp_en) begin
        resp_pending = 1'b1;
        resp_cnt = resp_delay;
      end
    end
    prev_start = (start === 1'b1);
  end

  // Global time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Drive one word and hold it until it is accepted (bounded).
  task automatic send_word(input logic [WW-1:0] d, input logic [AW-1:0] k);
    int  guard;
    bit  taken;
    guard = 0;
    taken = 1'b0;
    s_data  = d;
    key_sel = k;
    s_valid = 1'b1;
    while (!taken) begin
      taken = (s_ready === 1'b1);
      @(posedge clk);
      #1;
      guard++;
      if (!taken && guard > 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_word_stall: word %h not accepted, s_ready=%b required 1", d, s_ready);
        break;
      end
    end
  endtask

  // Queue the expected block, then stream its four words (key only valid on word 0).
  task automatic send_block(input logic [AES_LEN-1:0] blk, input logic [AW-1:0] key);
    exp_q.push_back({blk, key});
    for (int i = 0; i < 4; i++) begin
      send_word(blk[(3-i)*WW +: WW], (i == 0) ? key : AW'($urandom()));
    end
  endtask

  // Bounded wait until block_count reaches a value; the caller compares afterwards.
  task automatic wait_count(input logic [CW-1:0] target);
    int g;
    g = 0;
    while (block_count !== target && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; s_valid = 1'b0; s_data = '0; key_sel = '0; flush = 1'b0; done_man = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b required 0", start); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (block_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", block_count); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
    n_checks++; if (plaintext !== '0) begin n_fail++; $display("FAIL reset_pt: got %h required 0", plaintext); end
    n_checks++; if (key_addr !== '0) begin n_fail++; $display("FAIL reset_key: got %0d required 0", key_addr); end
    $display("reset: s_ready=%b busy=%b count=%0d", s_ready, busy, block_count);
  endtask

  task automatic test_single();
    logic [AES_LEN-1:0] blk;
    int s0;
    blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    s0 = start_count;
    resp_en = 1'b0;
    send_block(blk, 5'd5);
    s_valid = 1'b0;
    n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b required 1", start); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_issue: got %b required 0", s_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_issue: got %b required 1", busy); end
    @(posedge clk); #1;
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL single_start_drop: got %b required 0", start); end
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (s_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_wait: s_ready=%b busy=%b required 0/1", s_ready, busy); end
    n_checks++; if (plaintext !== blk) begin n_fail++; $display("FAIL single_pt: got %h required %h", plaintext, blk); end
    n_checks++; if (key_addr !== 5'd5) begin n_fail++; $display("FAIL single_key: got %0d required 5", key_addr); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b required 0", err); end
    done_man = 1'b1; @(posedge clk); #1; done_man = 1'b0;
    exp_count = 1;
    n_checks++; if (block_count !== CW'(exp_count)) begin n_fail++; $display("FAIL single_count: got %0d required %0d", block_count, exp_count); end
    n_checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_release: s_ready=%b busy=%b required 1/0", s_ready, busy); end
    n_checks++; if (start_count - s0 !== 1) begin n_fail++; $display("FAIL single_starts: got %0d required 1", start_count - s0); end
    $display("single: count=%0d", block_count);
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = start_count;
    resp_en = 1'b1; resp_delay = 20;
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 5'd3);
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 5'd9);
    s_valid = 1'b0;
    exp_count += 2;
    wait_count(CW'(exp_count));
    n_checks++; if (block_count !== CW'(exp_count)) begin n_fail++; $display("FAIL b2b_count: got %0d required %0d", block_count, exp_count); end
    n_checks++; if (start_count - s0 !== 2) begin n_fail++; $display("FAIL b2b_starts: got %0d required 2", start_count - s0); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_pending: got %0d blocks left required 0", exp_q.size()); end
    $display("back_to_back: count=%0d", block_count);
  endtask

  task automatic test_flush();
    resp_en = 1'b1; resp_delay = 3;
    send_word(32'hDEAD0001, 5'd7);
    send_word(32'hDEAD0002, 5'd8);
    s_data = 32'hBAD0BAD0; key_sel = 5'd1; flush = 1'b1; s_valid = 1'b1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b required 1", s_ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 5'd12);
    s_valid = 1'b0;
    exp_count += 1;
    wait_count(CW'(exp_count));
    n_checks++; if (block_count !== CW'(exp_count)) begin n_fail++; $display("FAIL flush_count: got %0d required %0d", block_count, exp_count); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL flush_pending: got %0d required 0", exp_q.size()); end
    $display("flush: count=%0d", block_count);
  endtask

  task automatic test_reset_mid();
    resp_en = 1'b0;
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 5'd21);
    s_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b required 1", busy); end
    nrst = 1'b0;
    #1;
    n_checks++; if (s_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL rmid_ctrl: s_ready=%b busy=%b start=%b err=%b required 1/0/0/0", s_ready, busy, start, err);
    end
    n_checks++; if (plaintext !== '0 || key_addr !== '0) begin n_fail++; $display("FAIL rmid_data: pt=%h key=%0d required 0/0", plaintext, key_addr); end
    n_checks++; if (block_count !== '0) begin n_fail++; $display("FAIL rmid_count: got %0d required 0", block_count); end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    exp_count = 0;
    done_man = 1'b1; @(posedge clk); #1; done_man = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (block_count !== CW'(exp_count)) begin n_fail++; $display("FAIL rmid_late_done: got %0d required %0d", block_count, exp_count); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b required 1", s_ready); end
    $display("reset_mid: count=%0d", block_count);
  endtask

  task automatic test_wrap();
    int s0;
    logic [CW-1:0] all_ones;
    all_ones = '1;
    resp_en = 1'b1; resp_delay = 0;
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      send_block({$urandom(), $urandom(), $urandom(), $urandom()}, AW'($urandom()));
    end
    s_valid = 1'b0;
    wait_count(all_ones);
    n_checks++; if (block_count !== all_ones) begin n_fail++; $display("FAIL wrap_max: got %0d required %0d", block_count, all_ones); end
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 5'd17);
    s_valid = 1'b0;
    wait_count('0);
    n_checks++; if (block_count !== '0) begin n_fail++; $display("FAIL wrap_zero: got %0d required 0", block_count); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL wrap_pending: got %0d required 0", exp_q.size()); end
    repeat (2) begin @(posedge clk); #1; end
    s0 = start_count;
    resp_en = 1'b0;
    done_man = 1'b1; @(posedge clk); #1; done_man = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (block_count !== '0) begin n_fail++; $display("FAIL collect_done: got %0d required 0", block_count); end
    n_checks++; if (s_ready !== 1'b1 || start_count != s0) begin n_fail++; $display("FAIL collect_state: s_ready=%b starts=%0d required 1/0", s_ready, start_count - s0); end
    exp_count = 0;
    $display("wrap: count=%0d", block_count);
  endtask

`ifdef AES_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    bit early;
    early = 1'b0;
    resp_en = 1'b0;
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 5'd2);
    s_valid = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); #1;
      if (err !== 1'b0) early = 1'b1;
    end
    n_checks++; if (early) begin n_fail++; $display("FAIL timeout_early: err high before %0d WAIT cycles", TO); end
    @(posedge clk); #1;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b required 1", err); end
    @(posedge clk); #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b required 0", err); end
    n_checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_ready: s_ready=%b busy=%b required 1/0", s_ready, busy); end
    n_checks++; if (block_count !== CW'(exp_count)) begin n_fail++; $display("FAIL timeout_count: got %0d required %0d", block_count, exp_count); end
    $display("timeout: err pulse seen, count=%0d", block_count);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_wrap();
`ifdef AES_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
Upstream feeder for the AES top. Assembles 128-bit plaintext blocks from a 32-bit valid/ready word stream and latches a per-block key ROM address. Drives the AES top's start, plaintext and key_addr inputs, then holds off new input until that top reports done. Keeps a running count of completed blocks.

Parameters:
aes_len, 128, plaintext block width; must equal word_width*4.
word_width, 32, input stream word width.
addr_width, 5, key ROM address width.
cnt_width, 16, width of the completed-block counter.
timeout_cycles, 1024, watchdog limit in cycles; used only with AES_LOADER_TIMEOUT_EN.

Ports:
clk  input  1  system clock, rising edge.
nrst  input  1  asynchronous active-low reset.
s_data  input  word_width  plaintext word.
s_valid  input  1  s_data valid.
s_ready  output  1  loader accepts a word this cycle.
key_sel  input  addr_width  key address, sampled with the first word of each block.
flush  input  1  synchronous discard of a partially collected block.
plaintext  output  aes_len  assembled block, to the AES top's plaintext input.
key_addr  output  addr_width  latched key address, to the AES top's key_addr input.
start  output  1  one-cycle start pulse, to the AES top's start input.
done  input  1  completion pulse from the AES top.
busy  output  1  high in ISSUE and WAIT.
block_count  output  cnt_width  completed blocks; wraps modulo 2^cnt_width.
err  output  1  watchdog timeout pulse; tied 0 without AES_LOADER_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on nrst.
- Reset values: state=COLLECT, word_cnt=0, plaintext=0, key_addr=0, start=0, busy=0, block_count=0, err=0, s_ready=1 after reset releases.
- Reset mid-operation forces the reset values. A partial block or an in-flight request is dropped.
- Handshake: a word transfers on a cycle with s_valid && s_ready. s_ready=1 only in COLLECT.
- Word order: the first word fills plaintext[127:96], then [95:64], then [63:32], then [31:0]. word_cnt is 2 bits.
- key_sel is captured into key_addr on the transfer where word_cnt==0. It is ignored on later words.
- State COLLECT:
  - On a transfer, store the word and increment word_cnt.
  - On the transfer with word_cnt==3, wrap word_cnt to 0 and go to ISSUE.
  - flush=1 clears word_cnt to 0; plaintext contents are don't-care. flush wins over a same-cycle transfer, and that word is dropped.
- State ISSUE: lasts exactly one cycle with start=1, busy=1, s_ready=0, then goes to WAIT. start is registered, so it asserts the cycle after the 4th word transfer.
- State WAIT:
  - busy=1, s_ready=0.
  - On done=1, increment block_count (wrapping at 2^cnt_width) and return to COLLECT. s_ready=1 on the next cycle.
- done is ignored in COLLECT and ISSUE. flush is ignored in ISSUE and WAIT.
- plaintext and key_addr stay stable from ISSUE until done is seen. The AES top registers the block one cycle after start, and this stability covers that.
- Minimum block period is 4 transfer cycles + 1 ISSUE cycle + the AES top's latency.
- Back-to-back operation: s_valid may be held high continuously. The loader stalls via s_ready with no data loss or duplication.

Optional Feature:
Macro AES_LOADER_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments every WAIT cycle.
  - If it reaches timeout_cycles-1 without done, err pulses for one cycle and state returns to COLLECT. block_count is not incremented.
  - A done in the same cycle as the timeout counts as done: no err, and block_count increments.
- Not defined: there is no watchdog counter, err is constant 0, and WAIT persists until done.

Test Plan:
1. Reset release, then words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with key_sel=5 -> plaintext=0x00112233445566778899AABBCCDDEEFF, key_addr=5, single-cycle start on the cycle after the 4th transfer, s_ready=0 until done, then block_count=1.
2. s_valid held high with 8 words while done is returned 20 cycles after each start -> exactly 2 start pulses, second block equals words 5-8, no word lost, block_count=2.
3. Two words accepted, then flush=1 together with s_valid=1 -> that word is dropped, word_cnt=0. The next 4 words form the block; key_addr is taken from key_sel on the first post-flush word.
4. Reset asserted (nrst=0) during WAIT -> all outputs at reset values immediately. A later done pulse causes no block_count change.
5. block_count preset via 65535 completions, or forced -> the next done gives block_count=0. A done pulse in COLLECT has no effect.
6. With AES_LOADER_TIMEOUT_EN and timeout_cycles=16, no done after start -> err=1 for one cycle exactly 16 cycles after WAIT entry, s_ready=1 next cycle, block_count unchanged.
